// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (count, words, checksum) and writes
// the words into instruction memory while holding the core in reset.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif

module imem_loader #(
  parameter int ADDR_W = `MEM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sim_load_en,
  output logic [ADDR_W-1:0] sim_addr,
  output logic [31:0]       sim_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t          state, state_nxt;
  logic [15:0]     word_cnt;
  logic [ADDR_W:0] word_addr;
  logic [1:0]      byte_idx;
  logic [7:0]      csum;
  logic [31:0]     word_buf;
  logic            accept;
  logic            start_ok;
  logic [16:0]     hdr_cnt;
  logic [16:0]     addr_inc;

  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  // Full count as it will be once the high header byte lands this cycle.
  assign hdr_cnt  = {1'b0, in_data, word_cnt[7:0]};
  // word_addr is one bit wider than sim_addr so a full-memory load never wraps.
  assign addr_inc = 17'(word_addr) + 17'd1;

  assign sim_addr = word_addr[ADDR_W-1:0];
  assign sim_data = word_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR0;
      HDR0: if (accept) state_nxt = HDR1;
      HDR1: if (accept) begin
        if (hdr_cnt > MAX_WORDS)   state_nxt = ERR;
        else if (hdr_cnt == 17'd0) state_nxt = CSUM;
        else                       state_nxt = DATA;
      end
      DATA:  if (accept && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = (addr_inc < {1'b0, word_cnt}) ? DATA : CSUM;
      CSUM:  if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    cpu_hold    = 1'b0;
    sim_load_en = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      HDR0, HDR1, DATA, CSUM: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      WRITE: begin
        cpu_hold    = 1'b1;
        sim_load_en = 1'b1;
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      word_addr <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      word_buf  <= '0;
    end else begin
      if (start_ok) begin
        word_addr <= '0;
        byte_idx  <= '0;
        csum      <= '0;
      end
      case (state)
        HDR0: if (accept) word_cnt[7:0]  <= in_data;
        HDR1: if (accept) word_cnt[15:8] <= in_data;
        DATA: if (accept) begin
          word_buf[8*byte_idx +: 8] <= in_data;
          csum                      <= csum ^ in_data;
          byte_idx                  <= byte_idx + 2'd1;
        end
        WRITE:   word_addr <= word_addr + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed frames, hand-written corner
// sequences and random frames, all compared against a frame-level model.
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          sim_load_en;
  logic [AW-1:0] sim_addr;
  logic [31:0]   sim_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  logic          stalled;

  logic [7:0]    frame[$];
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  logic [AW-1:0] exp_a[$];
  logic [31:0]   exp_d[$];
  logic          exp_done, exp_err;

  typedef struct {
    int         kind;
    logic [7:0] delta;
    int         gap;
    logic       e_done;
    logic       e_err;
    int         e_nw;
  } vec_t;
  vec_t vecs[8];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sim_load_en(sim_load_en),
    .sim_addr(sim_addr), .sim_data(sim_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sim_load_en === 1'b1) begin
      got_a.push_back(sim_addr);
      got_d.push_back(sim_data);
      check("in_ready_in_write", 32'(in_ready), 32'd0);
    end
  end

  // Frame-level reference: parse header, assemble words, XOR payload.
  task automatic model();
    int n;
    logic [7:0] cs;
    exp_a.delete();
    exp_d.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({frame[1], frame[0]});
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(AW'(i));
      exp_d.push_back({frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
      for (int j = 0; j < 4; j++) cs ^= frame[2+4*i+j];
    end
    if (frame[2+4*n] == cs) exp_done = 1'b1;
    else                    exp_err  = 1'b1;
  endtask

  // kind 0: two-word reference frame, 1: empty frame, 2: N=17 header only,
  // 3: full 16-word frame, 4: random length and payload.
  task automatic build(input int kind, input logic [7:0] delta);
    logic [79:0] f0 = 80'h02_00_13_00_00_00_93_00_10_00;
    int n;
    logic [7:0] b;
    logic [7:0] cs;
    frame.delete();
    cs = 8'h00;
    case (kind)
      0: begin
        for (int i = 0; i < 10; i++) frame.push_back(f0[79-8*i -: 8]);
        frame.push_back(8'h90 ^ delta);
      end
      2: begin
        frame.push_back(8'h11);
        frame.push_back(8'h00);
      end
      default: begin
        n = (kind == 1) ? 0 : (kind == 3) ? 16 : int'($urandom_range(0, 16));
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < 4*n; i++) begin
          b = (kind == 3) ? 8'(i*7 + 1) : 8'($urandom);
          frame.push_back(b);
          cs ^= b;
        end
        frame.push_back(cs ^ delta);
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_accept();
    int t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      stalled = 1'b1;
      $display("FAIL accept_timeout: in_ready=%b after 100 cycles, expected 1", in_ready);
    end else begin
      step();
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int k = lo; k < hi && !stalled; k++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      in_valid = 1'b0;
      repeat (g) step();
      in_valid = 1'b1;
      in_data  = frame[k];
      wait_accept();
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_result(input string tag);
    check({tag, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check({tag, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
      check({tag, "_data"}, got_d[i], exp_d[i]);
    end
    check({tag, "_done"},     32'(done),     32'(exp_done));
    check({tag, "_error"},    32'(error),    32'(exp_err));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int gap_max);
    got_a.delete();
    got_d.delete();
    stalled = 1'b0;
    model();
    pulse_start();
    check({tag, "_hold_busy"}, 32'(cpu_hold), 32'd1);
    send_range(0, frame.size(), gap_max);
    repeat (3) step();
    compare_result(tag);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stalled  = 1'b0;
    #2 reset = 1'b1;
    repeat (2) step();
    check("rst_in_ready",    32'(in_ready),    32'd0);
    check("rst_load_en",     32'(sim_load_en), 32'd0);
    check("rst_addr",        32'(sim_addr),    32'd0);
    check("rst_data",        sim_data,         32'd0);
    check("rst_cpu_hold",    32'(cpu_hold),    32'd0);
    check("rst_done_error",  32'({done, error}), 32'd0);
    reset = 1'b0;
    step();

    vecs[0] = '{0, 8'h00, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{0, 8'h01, 0, 1'b0, 1'b1, 2};
    vecs[2] = '{1, 8'h00, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{1, 8'h01, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{2, 8'h00, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{3, 8'h00, 0, 1'b1, 1'b0, 16};
    vecs[6] = '{0, 8'h00, 2, 1'b1, 1'b0, 2};
    vecs[7] = '{3, 8'h5a, 1, 1'b0, 1'b1, 16};
    for (int v = 0; v < 8; v++) begin
      build(vecs[v].kind, vecs[v].delta);
      run_frame($sformatf("vec%0d", v), vecs[v].gap);
      check($sformatf("vec%0d_tbl_nw", v),    32'(got_a.size()), 32'(vecs[v].e_nw));
      check($sformatf("vec%0d_tbl_done", v),  32'(done),  32'(vecs[v].e_done));
      check($sformatf("vec%0d_tbl_error", v), 32'(error), 32'(vecs[v].e_err));
    end

    // A start pulse while the payload is streaming must not restart the session.
    build(0, 8'h00);
    got_a.delete();
    got_d.delete();
    stalled = 1'b0;
    model();
    pulse_start();
    send_range(0, 4, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_hold",  32'(cpu_hold), 32'd1);
    check("busy_start_ready", 32'(in_ready), 32'd1);
    send_range(4, frame.size(), 0);
    repeat (3) step();
    compare_result("busy_start");

    for (int r = 0; r < 10; r++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build(4, d);
      run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 3)));
    end

    // Reset after six payload bytes: one word already written, then abort.
    build(0, 8'h00);
    got_a.delete();
    got_d.delete();
    stalled = 1'b0;
    pulse_start();
    send_range(0, 8, 0);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready),    32'd0);
    check("midrst_load_en",  32'(sim_load_en), 32'd0);
    check("midrst_addr",     32'(sim_addr),    32'd0);
    check("midrst_data",     sim_data,         32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold),    32'd0);
    check("midrst_flags",    32'({done, error}), 32'd0);
    step();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h93;
    repeat (5) step();
    check("midrst_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    check("midrst_nwrites",    32'(got_a.size()), 32'd1);
    check("midrst_idle_hold",  32'(cpu_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
